// File: rtl/wvb_pkg.sv
// wvb_pkg: waveform-buffer header layout, read FSM states and trigger codes
// shared by the WVB write and read controllers.
package wvb_pkg;

   localparam int LTC_HI      = 159;
   localparam int LTC_LO      = 112;
   localparam int START_HI    = 111;
   localparam int START_LO    = 100;
   localparam int STOP_HI     = 99;
   localparam int STOP_LO     = 88;
   localparam int TRIG_SRC_HI = 87;
   localparam int TRIG_SRC_LO = 86;
   localparam int CNST_BIT    = 85;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_READ,
      S_DRAIN,
      S_DONE
   } rd_state_t;

   typedef enum logic [1:0] {
      TRIG_SW     = 2'd0,
      TRIG_DISCR  = 2'd1,
      TRIG_THRESH = 2'd2,
      TRIG_EXT    = 2'd3
   } trig_src_t;

endpackage

// File: rtl/wvb_rd_skid_fifo.sv
// wvb_rd_skid_fifo: 4-deep sample FIFO that absorbs the RAM read latency
// under back-pressure; its occupancy feeds the read-issue credit.
module wvb_rd_skid_fifo #(
   parameter int P_WIDTH = 23
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en_i,
   input  logic [P_WIDTH-1:0] wr_data_i,
   input  logic               rd_en_i,
   output logic [P_WIDTH-1:0] rd_data_o,
   output logic               valid_o,
   output logic [2:0]         count_o
);

   logic [P_WIDTH-1:0] mem_q [4];
   logic [1:0]         wp_q, rp_q;
   logic [2:0]         cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_en_i) begin
            mem_q[wp_q] <= wr_data_i;
            wp_q        <= wp_q + 2'd1;
         end
         if (rd_en_i) rp_q <= rp_q + 2'd1;
         cnt_q <= cnt_q + {2'b00, wr_en_i} - {2'b00, rd_en_i};
      end
   end

   assign rd_data_o = mem_q[rp_q];
   assign valid_o   = cnt_q != 3'd0;
   assign count_o   = cnt_q;

endmodule

// File: rtl/wvb_rd_ctrl.sv
// wvb_rd_ctrl: pops WVB event headers, streams each event's samples out of the
// waveform RAM onto a valid/ready stream and returns a read pointer per event.
module wvb_rd_ctrl
   import wvb_pkg::*;
#(
   parameter int P_ADR_WIDTH  = 12,
   parameter int P_DATA_WIDTH = 22,
   parameter int P_HDR_WIDTH  = 160
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    hdr_empty,
   input  logic [P_HDR_WIDTH-1:0]  hdr_data,
   output logic                    hdr_rdreq,
   output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
   input  logic [P_DATA_WIDTH-1:0] wvb_data,
   output logic [P_HDR_WIDTH-1:0]  hdr_out,
   output logic                    evt_start,
   output logic [P_DATA_WIDTH-1:0] dout,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic                    dout_last,
   output logic                    busy,
   output logic                    done,
   output logic [P_ADR_WIDTH-1:0]  rd_ptr
);

   localparam logic [P_ADR_WIDTH-1:0] ADR_ONE = P_ADR_WIDTH'(1);

   rd_state_t                state_q;
   logic [P_ADR_WIDTH-1:0]   cur_addr_q, rem_q, rd_ptr_q, start_addr, stop_addr;
   logic [P_HDR_WIDTH-1:0]   hdr_q;
   logic                     hdr_rdreq_q, evt_start_q, busy_q, done_q;
   logic [1:0]               tag_v_q, tag_l_q, in_flight;
   logic [2:0]               fifo_cnt;
   logic [P_DATA_WIDTH:0]    fifo_dout;
   logic                     fifo_valid, issue, is_last, xfer;

   assign start_addr = hdr_q[START_HI:START_LO];
   assign stop_addr  = hdr_q[STOP_HI:STOP_LO];
   assign in_flight  = {1'b0, tag_v_q[1]} + {1'b0, tag_v_q[0]};
   // a read may only issue if its sample is guaranteed a skid slot on arrival
   assign issue      = (state_q == S_READ) && ((fifo_cnt + {1'b0, in_flight}) < 3'd4);
   assign is_last    = rem_q == ADR_ONE;
   assign xfer       = fifo_valid & dout_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cur_addr_q  <= '0;
         rem_q       <= '0;
         rd_ptr_q    <= '0;
         hdr_q       <= '0;
         hdr_rdreq_q <= 1'b0;
         evt_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         hdr_rdreq_q <= 1'b0;
         evt_start_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            S_IDLE: if (en && !hdr_empty) begin
               hdr_rdreq_q <= 1'b1;
               evt_start_q <= 1'b1;
               busy_q      <= 1'b1;
               hdr_q       <= hdr_data;
               state_q     <= S_LOAD;
            end
            S_LOAD: begin
               // a zero span encodes a full-buffer event of 2^P_ADR_WIDTH samples
               cur_addr_q <= start_addr;
               rem_q      <= stop_addr - start_addr + ADR_ONE;
               state_q    <= S_READ;
            end
            S_READ: if (issue) begin
               cur_addr_q <= cur_addr_q + ADR_ONE;
               rem_q      <= rem_q - ADR_ONE;
               if (is_last) state_q <= S_DRAIN;
            end
            S_DRAIN: if (tag_v_q == 2'b00 && !fifo_valid) begin
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               rd_ptr_q <= stop_addr + ADR_ONE;
               state_q  <= S_DONE;
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // tags ride alongside the 2-cycle RAM read; index 1 lines up with wvb_data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_v_q <= '0;
         tag_l_q <= '0;
      end else begin
         tag_v_q <= {tag_v_q[0], issue};
         tag_l_q <= {tag_l_q[0], issue & is_last};
      end
   end

   wvb_rd_skid_fifo #(
      .P_WIDTH(P_DATA_WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (tag_v_q[1]),
      .wr_data_i ({tag_l_q[1], wvb_data}),
      .rd_en_i   (xfer),
      .rd_data_o (fifo_dout),
      .valid_o   (fifo_valid),
      .count_o   (fifo_cnt)
   );

   assign hdr_rdreq   = hdr_rdreq_q;
   assign evt_start   = evt_start_q;
   assign hdr_out     = hdr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign rd_ptr      = rd_ptr_q;
   assign wvb_rd_addr = cur_addr_q;
   assign dout        = fifo_dout[P_DATA_WIDTH-1:0];
   assign dout_valid  = fifo_valid;
   assign dout_last   = fifo_dout[P_DATA_WIDTH] & fifo_valid;

endmodule
